// File: rtl/code_mem_pkg.sv
// Shared types and default widths for the code-memory responder.
package code_mem_pkg;

    localparam int CODE_ADDR_W = 10;
    localparam int CODE_DATA_W = 32;
    localparam int CODE_WID_W  = 3;

    typedef struct packed {
        logic [CODE_ADDR_W-1:0] addr;
        logic [CODE_WID_W-1:0]  wid;
    } code_req_t;

    typedef struct packed {
        logic [CODE_DATA_W-1:0] data;
        logic [CODE_WID_W-1:0]  wid;
    } code_rsp_t;

endpackage

// File: rtl/code_mem_req_fifo.sv
// Small synchronous request FIFO with a registered not-full flag.
// DEPTH must be a power of two so the pointers wrap naturally.
module code_mem_req_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty,
    output logic         not_full_q
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, next_count;

    assign next_count = count + CW'(push) - CW'(pop);
    assign head       = mem[rd_ptr];
    assign full       = (count == CW'(DEPTH));
    assign empty      = (count == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            not_full_q <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count      <= next_count;
            // Registered so the requester sees a flop, not a path through pop/load.
            not_full_q <= (next_count < CW'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/code_mem_ctrl.sv
// Code-memory responder: queues fetch requests, reads the code SRAM through a
// fixed-latency pipeline and returns words tagged with the requesting warp id.
module code_mem_ctrl
    import code_mem_pkg::*;
#(
    parameter int ADDR_W     = CODE_ADDR_W,
    parameter int DATA_W     = CODE_DATA_W,
    parameter int WID_W      = CODE_WID_W,
    parameter int FIFO_DEPTH = 4,
    parameter int RD_LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              code_mem_available_o,
    input  logic              code_read_valid_i,
    input  logic [ADDR_W-1:0] code_read_addr_i,
    input  logic [WID_W-1:0]  code_read_wid_i,
    output logic              code_read_ready_o,
    output logic [DATA_W-1:0] code_read_data_o,
    output logic [WID_W-1:0]  code_read_rsp_wid_o,
    input  logic              load_valid_i,
    input  logic [ADDR_W-1:0] load_addr_i,
    input  logic [DATA_W-1:0] load_data_i
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    code_req_t req, head;
    code_rsp_t rsp_q;
    logic      push, issue, fifo_full, fifo_empty;

    logic [RD_LATENCY:1] vld_pipe;
    logic [WID_W-1:0]    wid_pipe  [RD_LATENCY:1];
    logic [DATA_W-1:0]   data_pipe [RD_LATENCY:1];

    assign req.addr = code_read_addr_i;
    assign req.wid  = code_read_wid_i;
    assign push     = code_read_valid_i && code_mem_available_o && !fifo_full;
    // A loader write owns the SRAM port for the cycle.
    assign issue    = !fifo_empty && !load_valid_i;

    code_mem_req_fifo #(
        .W     ($bits(code_req_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_req_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .pop        (issue),
        .push_data  (req),
        .head       (head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .not_full_q (code_mem_available_o)
    );

    always_ff @(posedge clk) begin
        if (load_valid_i) mem[load_addr_i] <= load_data_i;
        if (issue) data_pipe[1] <= mem[head.addr];
        for (int i = 2; i <= RD_LATENCY; i++) data_pipe[i] <= data_pipe[i-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            for (int i = 1; i <= RD_LATENCY; i++) wid_pipe[i] <= '0;
            rsp_q             <= '0;
            code_read_ready_o <= 1'b0;
        end else begin
            vld_pipe[1] <= issue;
            wid_pipe[1] <= head.wid;
            for (int i = 2; i <= RD_LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                wid_pipe[i] <= wid_pipe[i-1];
            end
            code_read_ready_o <= vld_pipe[RD_LATENCY];
            if (vld_pipe[RD_LATENCY]) begin
                rsp_q.data <= data_pipe[RD_LATENCY];
                rsp_q.wid  <= wid_pipe[RD_LATENCY];
            end
        end
    end

    assign code_read_data_o    = rsp_q.data;
    assign code_read_rsp_wid_o = rsp_q.wid;

endmodule

// File: tb/tb_code_mem_ctrl.sv
// Bench for code_mem_ctrl: directed scenarios plus random traffic against a
// queue-based reference of accepted/issued requests and a shadow code memory.
module tb_code_mem_ctrl;
    localparam int ADDR_W = 10, DATA_W = 32, WID_W = 3, DEPTH = 4, LAT = 2;

    logic              clk = 1'b0, rst_n = 1'b0;
    logic              available, valid, ready, load_valid;
    logic [ADDR_W-1:0] addr, load_addr;
    logic [WID_W-1:0]  wid, rsp_wid;
    logic [DATA_W-1:0] data, load_data;

    always #5 clk = ~clk;

    code_mem_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WID_W(WID_W),
        .FIFO_DEPTH(DEPTH), .RD_LATENCY(LAT)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .code_mem_available_o (available),
        .code_read_valid_i    (valid),
        .code_read_addr_i     (addr),
        .code_read_wid_i      (wid),
        .code_read_ready_o    (ready),
        .code_read_data_o     (data),
        .code_read_rsp_wid_o  (rsp_wid),
        .load_valid_i         (load_valid),
        .load_addr_i          (load_addr),
        .load_data_i          (load_data)
    );

    typedef struct { logic [ADDR_W-1:0] addr; logic [WID_W-1:0] wid; } req_s;
    typedef struct { logic [DATA_W-1:0] data; logic [WID_W-1:0] wid; int due; } rsp_s;

    logic [DATA_W-1:0] m_sram [1<<ADDR_W];
    req_s              m_q[$];     // accepted, not yet issued
    rsp_s              m_exp[$];   // issued, waiting for their ready pulse
    req_s              pend[$];    // requester side, held until accepted
    bit                m_avail, last_acc;
    logic [DATA_W-1:0] m_data;
    logic [WID_W-1:0]  m_wid;
    int                cyc, n_chk, n_fail;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic idle_inputs();
        valid = 0; addr = '0; wid = '0;
        load_valid = 0; load_addr = '0; load_data = '0;
    endtask

    // One clock edge: update the reference from the inputs present at the edge, then check.
    task automatic cycle();
        bit   acc, iss;
        req_s r;
        rsp_s e;
        acc = valid && m_avail;
        iss = (m_q.size() > 0) && !load_valid;
        @(posedge clk);
        cyc++;
        if (iss) begin
            r = m_q.pop_front();
            m_exp.push_back('{m_sram[r.addr], r.wid, cyc + LAT});
        end
        if (load_valid) m_sram[load_addr] = load_data;
        if (acc) m_q.push_back('{addr, wid});
        m_avail  = (m_q.size() < DEPTH);
        last_acc = acc;
        #1;
        chk("available", available, m_avail);
        if (m_exp.size() > 0 && m_exp[0].due == cyc) begin
            e = m_exp.pop_front();
            m_data = e.data;
            m_wid  = e.wid;
            chk("ready_pulse", ready, 1);
        end else begin
            chk("ready_idle", ready, 0);
        end
        chk("data", data, m_data);
        chk("rsp_wid", rsp_wid, m_wid);
    endtask

    // Drive pending requests (held until accepted) for n edges; optional load for the first nload edges.
    task automatic run(input int n, input int nload, input logic [ADDR_W-1:0] la_base,
                       input logic [DATA_W-1:0] ld_base, output int n_acc_load);
        n_acc_load = 0;
        for (int c = 0; c < n; c++) begin
            valid = (pend.size() > 0);
            if (valid) begin addr = pend[0].addr; wid = pend[0].wid; end
            load_valid = (c < nload);
            load_addr  = la_base + ADDR_W'(c);
            load_data  = ld_base + DATA_W'(c);
            cycle();
            if (last_acc) begin
                void'(pend.pop_front());
                if (c < nload) n_acc_load++;
            end
        end
        idle_inputs();
    endtask

    task automatic load_word(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        idle_inputs();
        load_valid = 1; load_addr = a; load_data = d;
        cycle();
        idle_inputs();
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        #2;
        chk("rst_available", available, 0);
        chk("rst_ready", ready, 0);
        chk("rst_data", data, 0);
        chk("rst_wid", rsp_wid, 0);
        @(posedge clk); #1;
        rst_n = 1;
        m_q.delete(); m_exp.delete();
        m_avail = 0; m_data = '0; m_wid = '0;
    endtask

    initial begin
        int   nacc;
        req_s cur;
        bit   have;
        n_chk = 0; n_fail = 0; cyc = 0;
        do_reset();

        // Fill every word so random reads always hit defined data.
        for (int a = 0; a < (1 << ADDR_W); a++) load_word(ADDR_W'(a), $urandom);

        // Single read after a load: pulse three edges after acceptance.
        load_word(10'h010, 32'hDEADBEEF);
        pend.push_back('{10'h010, 3'd3});
        run(8, 0, '0, '0, nacc);
        chk("beef_data", data, 32'hDEADBEEF);
        chk("beef_wid", rsp_wid, 3);

        // Back-to-back requests return in order.
        for (int i = 0; i < 4; i++) load_word(ADDR_W'(i), 32'hA0 + DATA_W'(i));
        for (int i = 0; i < 4; i++) pend.push_back('{ADDR_W'(i), WID_W'(i)});
        run(10, 0, '0, '0, nacc);
        chk("b2b_last_data", data, 32'hA3);

        // Loads block issue: only DEPTH accepts fit while loading.
        for (int i = 0; i < 5; i++) pend.push_back('{ADDR_W'(4 + i), WID_W'(i)});
        run(16, 6, 10'h100, 32'h5500_0000, nacc);
        chk("accepts_during_load", nacc, DEPTH);
        chk("all_accepted", pend.size(), 0);

        // Load to a queued address stalls issue and the read sees the new word.
        pend.push_back('{10'h3FF, 3'd5});
        run(1, 0, '0, '0, nacc);
        load_word(10'h3FF, 32'h12345678);
        run(6, 0, '0, '0, nacc);
        chk("stall_data", data, 32'h12345678);

        // Reset with requests in flight discards them.
        pend.push_back('{10'h020, 3'd1});
        pend.push_back('{10'h021, 3'd2});
        run(3, 0, '0, '0, nacc);
        do_reset();
        run(6, 0, '0, '0, nacc);
        pend.push_back('{10'h010, 3'd7});
        run(6, 0, '0, '0, nacc);
        chk("post_rst_data", data, 32'hDEADBEEF);
        chk("post_rst_wid", rsp_wid, 7);

        // Random traffic; second half loads heavily to force backpressure.
        have = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!have && $urandom_range(0, 9) < 6) begin
                cur.addr = ADDR_W'($urandom);
                cur.wid  = WID_W'($urandom);
                have = 1;
            end
            valid = have;
            addr  = cur.addr;
            wid   = cur.wid;
            load_valid = (c < 1500) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 1) == 0);
            load_addr  = ADDR_W'($urandom);
            load_data  = $urandom;
            cycle();
            if (last_acc) have = 0;
        end
        idle_inputs();
        for (int c = 0; c < 10; c++) cycle();
        chk("drained", m_q.size() + m_exp.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/code_mem_ctrl.md
Name: code_mem_ctrl

Overview:
Code-memory responder that serves SM fetch read requests. It accepts requests (address + warp id) through a valid/available handshake and queues them in a small request FIFO. It reads a synchronous code SRAM with a fixed pipeline latency and returns instruction words tagged with the requesting warp id. A loader write port fills the SRAM with kernel code before and between launches.

Parameters:
ADDR_W, 10, code memory word-address width (`CODE_MEM_ADDR_WIDTH); memory holds 2**ADDR_W words
DATA_W, 32, instruction word width (`CODE_MEM_DATA_WIDTH)
WID_W, 3, warp id width (`DEPTH_WARP)
FIFO_DEPTH, 4, request FIFO entries (power of two, >=2)
RD_LATENCY, 2, SRAM read pipeline stages (>=1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
code_mem_available_o  output  1  request FIFO can accept a request this cycle
code_read_valid_i  input  1  read request valid
code_read_addr_i  input  ADDR_W  read word address
code_read_wid_i  input  WID_W  warp id of the request
code_read_ready_o  output  1  one-cycle pulse: response data valid
code_read_data_o  output  DATA_W  instruction word read
code_read_rsp_wid_o  output  WID_W  warp id of the response
load_valid_i  input  1  loader write strobe
load_addr_i  input  ADDR_W  loader write address
load_data_i  input  DATA_W  loader write data

Behaviour:
- Reset values: code_mem_available_o=0, code_read_ready_o=0, code_read_data_o=0, code_read_rsp_wid_o=0. FIFO count, pointers and latency pipeline are cleared. SRAM contents are not reset.
- code_mem_available_o is registered and equals (next_count < FIFO_DEPTH). It rises at the first edge after rst_n deasserts. It does not depend on code_read_valid_i.
- Accept: push occurs on an edge where code_read_valid_i && code_mem_available_o. Requests arriving while available=0 are ignored; the requester holds them.
- Issue: on each edge where the FIFO is non-empty and load_valid_i=0, pop the head and start an SRAM read. At most one issue per cycle.
- Load priority: load_valid_i=1 writes SRAM[load_addr_i] and blocks issue for that cycle. A read issued later to the same address returns the new data.
- Count update: count += push - pop. Push and pop may occur on the same edge; push is still gated by the registered available, so a full FIFO does not accept even when popping.
- Latency:
  - Request accepted at edge E0 is issued at E1 at the earliest (no bypass).
  - Data/wid/valid travel through RD_LATENCY registered stages.
  - code_read_ready_o is high for exactly one cycle, between E(1+RD_LATENCY) and E(2+RD_LATENCY). Minimum latency is 2+RD_LATENCY edges.
- Throughput is one response per cycle. Responses return in acceptance order. There is no response backpressure; the consumer must always sink.
- data_o and rsp_wid_o update only when a response is produced and hold otherwise.
- Reset mid-operation: queued and in-flight requests are discarded. No response pulse appears after rst_n rises for requests accepted before reset.
- Addresses span the full 2**ADDR_W range; there is no out-of-range case.

Decomposition:
- Shared package code_mem_pkg: code_req_t {addr, wid} and code_rsp_t {data, wid} typedefs, plus default width constants tied to define.sv macros.
- One sub-module: code_mem_req_fifo. It is a parameterised synchronous FIFO with push/pop, count, full/empty and registered not-full.
- SRAM array and latency pipeline stay in the top module.

Test Plan:
- Load SRAM[0x010]=0xDEADBEEF, then request addr 0x010 wid 3 accepted at E0 → ready_o pulse between E3 and E4 (RD_LATENCY=2) with data 0xDEADBEEF and rsp_wid 3; exactly one pulse.
- Preload addr 0..3 with 0xA0..0xA3 and issue back-to-back requests wid 0..3 → four consecutive ready pulses carrying data 0xA0..0xA3 and wids 0..3 in order.
- Hold load_valid_i high for 6 cycles while valid is held with addrs 4..8 → available drops after 4 accepts. The 5th request is accepted only after load ends and a pop frees space. All 5 responses return in order with no loss or duplication.
- Request addr 0x3FF pending in FIFO and load 0x3FF=0x12345678 in the same cycle → issue stalls one cycle, and the response data is 0x12345678.
- Two requests in flight, then pulse rst_n low for 1 cycle → all outputs return to reset values and no ready pulse appears afterward. A subsequent read of a preloaded address returns the retained data.
- Randomised valid/load traffic checked against a scoreboard reference queue, plus an assertion that ready_o is never high on 2 cycles for one request.
